disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Upstream driver for the 3-to-8 active-low digit decoder on the 8-digit seven-segment display path.
- Time-multiplexes eight hex digits: produces the decoder's 3-bit select and its g1/g2a/g2b enables, plus the active-low segment pattern for the selected digit.
- Each digit change is preceded by a blanking gap to prevent ghosting.
- New display content is double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new data.

Parameters:
- SCAN_DIV, 50000, clk cycles a digit is lit per slot (show phase); must be >= 1.
- BLANK_CYCLES, 100, clk cycles of blanking at the start of each slot; must be >= 1.
- CNT_W, 16, phase counter width; must hold max(SCAN_DIV, BLANK_CYCLES) - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle request to stage new display content.
- data_in  input  32  eight hex nibbles; nibble i = data_in[4i+3:4i] goes to digit i.
- mask_in  input  8  bit i = 1 enables digit i.
- dp_in  input  8  bit i = 1 lights the decimal point of digit i.
- load_ack  output  1  one-cycle pulse confirming a load was captured.
- frame_done  output  1  one-cycle pulse on the last cycle of slot 7.
- sel  output  3  decoder select = current digit index.
- g1  output  1  decoder enable, active high.
- g2a  output  1  decoder enable, active low.
- g2b  output  1  decoder enable, active low.
- seg  output  8  segments {a,b,c,d,e,f,g,dp}, active low (0 = lit).

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - state=BLANK, idx=0, phase counter=0.
  - active data/mask/dp = 0; pending_valid = 0.
  - sel=0, g1=0, g2a=1, g2b=1, seg=8'hFF, load_ack=0, frame_done=0.
  - Display is dark until the first load takes effect.
- Reset asserted mid-slot aborts the slot immediately; no pulse is emitted.
- Slot structure: a frame is 8 slots, idx 0..7 in order, with no skipping of masked digits.
  - Each slot is BLANK for BLANK_CYCLES cycles, then SHOW for SCAN_DIV cycles.
  - Slot length = BLANK_CYCLES + SCAN_DIV; frame length = 8 x that, constant.
- FSM states:
  - BLANK -> SHOW when the counter reaches BLANK_CYCLES-1.
  - SHOW -> BLANK when the counter reaches SCAN_DIV-1.
  - The counter clears on every transition.
  - idx increments (7 wraps to 0) on the SHOW->BLANK transition.
  - sel changes only on that transition, so it is always stable while enables are asserted.
- Enables:
  - In BLANK, or in SHOW with active mask[idx]=0: g1=0, g2a=1, g2b=1, seg=8'hFF.
  - In SHOW with mask[idx]=1: g1=1, g2a=0, g2b=0.
    - seg[7:1] = hex code of nibble idx.
    - seg[0] = ~dp[idx].
- Hex codes (seg with dp off), nibbles 0..F: 03 9F 25 0D 99 49 41 1F 01 09 11 C1 63 85 61 71.
- Load handshake:
  - load=1 copies data_in/mask_in/dp_in into the pending registers and sets pending_valid.
  - load_ack=1 in the following cycle.
  - A second load before the frame boundary overwrites pending; each load gets its own ack.
- Frame boundary: the SHOW->BLANK transition with idx=7.
  - frame_done=1 for that cycle.
  - If pending_valid, pending is copied to active and pending_valid is cleared; slot 0 of the next frame uses the new content.
- Simultaneous load and frame boundary: data_in/mask_in/dp_in go straight to active, pending_valid ends 0, and load_ack pulses next cycle.
- load held high for multiple cycles counts as one load per cycle.

Test Plan:
1. Reset check. Use SCAN_DIV=4, BLANK_CYCLES=2. Drive rst_n=0, then release.
   -> sel=0, g1=0, g2a=1, g2b=1, seg=FF, no pulses.
   -> With mask 0, enables stay off for an entire 48-cycle frame.
   -> frame_done pulses on cycle 47 after release.
2. Single load and slot timing. Load data_in=32'h76543210, mask_in=FF, dp_in=00 during frame 0.
   -> load_ack pulses exactly one cycle later.
   -> Frame 1, slot 0: 2 cycles blank, then 4 cycles with g1=1, g2a=0, g2b=0, sel=0, seg=03.
   -> Slot 1: sel=1, seg=9F.
   -> Slot 7: sel=7, seg=1F.
3. Mask and decimal point. Load data_in=32'hFEDCBA98, mask_in=8'b0000_0101, dp_in=8'b0000_0100.
   -> Slot 0: seg=01.
   -> Slot 1: g1=0, seg=FF throughout.
   -> Slot 2: seg=10 (A with dp lit).
   -> Slot timing is unchanged.
4. Tearing check. Issue a load mid-frame with different data.
   -> Remaining slots of the current frame still show old values.
   -> New values appear from slot 0 after frame_done.
   -> Two loads in one frame: only the second is displayed, and two load_ack pulses are seen.
5. Boundary collision. Assert load in the exact frame_done cycle.
   -> The next frame shows that load's data.
   -> load_ack pulses next cycle, and no stale pending data appears in the frame after.
6. Async reset mid-SHOW. Drop rst_n while g1=1 in slot 3.
   -> g1=0 and seg=FF immediately, without waiting for a clk edge.
   -> After release: sel=0, display dark until a new load.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 8-digit seven-segment scan driver for a 3-to-8 active-low decoder
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  mask_in,
    input  logic [7:0]  dp_in,
    output logic        load_ack,
    output logic        frame_done,
    output logic [2:0]  sel,
    output logic        g1,
    output logic        g2a,
    output logic        g2b,
    output logic [7:0]  seg
);

    typedef enum logic [0:0] {BLANK, SHOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      act_data_q, act_data_d, pend_data_q;
    logic [7:0]       act_mask_q, act_mask_d, pend_mask_q;
    logic [7:0]       act_dp_q, act_dp_d, pend_dp_q;
    logic             pend_valid_q;
    logic             boundary;
    logic             lit_d;
    logic [3:0]       nib_d;
    logic [7:0]       hex_d;
    logic [7:0]       seg_d;
    logic             frame_done_d;

    // Sequencing and frame-boundary buffer swap
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        boundary   = 1'b0;
        act_data_d = act_data_q;
        act_mask_d = act_mask_q;
        act_dp_d   = act_dp_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    state_d  = BLANK;
                    cnt_d    = '0;
                    idx_d    = idx_q + 3'd1;
                    boundary = (idx_q == 3'd7);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
        if (boundary) begin
            // A load landing on the boundary itself beats any older pending content
            if (load) begin
                act_data_d = data_in;
                act_mask_d = mask_in;
                act_dp_d   = dp_in;
            end else if (pend_valid_q) begin
                act_data_d = pend_data_q;
                act_mask_d = pend_mask_q;
                act_dp_d   = pend_dp_q;
            end
        end
    end

    // Output values are derived from the next state so the registered outputs line up with it
    always_comb begin
        nib_d = act_data_d[idx_d*4 +: 4];
        case (nib_d)
            4'h0: hex_d = 8'h03;
            4'h1: hex_d = 8'h9F;
            4'h2: hex_d = 8'h25;
            4'h3: hex_d = 8'h0D;
            4'h4: hex_d = 8'h99;
            4'h5: hex_d = 8'h49;
            4'h6: hex_d = 8'h41;
            4'h7: hex_d = 8'h1F;
            4'h8: hex_d = 8'h01;
            4'h9: hex_d = 8'h09;
            4'hA: hex_d = 8'h11;
            4'hB: hex_d = 8'hC1;
            4'hC: hex_d = 8'h63;
            4'hD: hex_d = 8'h85;
            4'hE: hex_d = 8'h61;
            default: hex_d = 8'h71;
        endcase
        lit_d        = (state_d == SHOW) && act_mask_d[idx_d];
        seg_d        = lit_d ? {hex_d[7:1], ~act_dp_d[idx_d]} : 8'hFF;
        frame_done_d = (state_d == SHOW) && (idx_d == 3'd7) &&
                       (cnt_d == CNT_W'(SCAN_DIV - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_mask_q   <= '0;
            act_dp_q     <= '0;
            pend_data_q  <= '0;
            pend_mask_q  <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            load_ack     <= 1'b0;
            frame_done   <= 1'b0;
            sel          <= '0;
            g1           <= 1'b0;
            g2a          <= 1'b1;
            g2b          <= 1'b1;
            seg          <= 8'hFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_data_q <= act_data_d;
            act_mask_q <= act_mask_d;
            act_dp_q   <= act_dp_d;
            if (boundary) begin
                pend_valid_q <= 1'b0;
            end else if (load) begin
                pend_data_q  <= data_in;
                pend_mask_q  <= mask_in;
                pend_dp_q    <= dp_in;
                pend_valid_q <= 1'b1;
            end
            load_ack   <= load;
            frame_done <= frame_done_d;
            sel        <= idx_d;
            g1         <= lit_d;
            g2a        <= ~lit_d;
            g2b        <= ~lit_d;
            seg        <= seg_d;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - directed table-driven bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  mask_in = '0;
    logic [7:0]  dp_in = '0;
    logic        load_ack, frame_done, g1, g2a, g2b;
    logic [2:0]  sel;
    logic [7:0]  seg;

    disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
        .mask_in(mask_in), .dp_in(dp_in), .load_ack(load_ack),
        .frame_done(frame_done), .sel(sel), .g1(g1), .g2a(g2a),
        .g2b(g2b), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  mask;
        logic [7:0]  dp;
        logic [63:0] segs;
    } vec_t;

    vec_t tbl [5];
    int   n_pass = 0;
    int   n_tot  = 0;
    logic prev_load = 1'b0;

    task automatic chk(input string name, input int f, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s frame%0d cyc%0d: got %h want %h", name, f, c, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk ncyc cycles of a frame that starts at slot 0 blank, checking every output each cycle.
    // Loads from table entries r1/r2 are driven at cycles lc1/lc2 (-1 = none).
    task automatic run_frame(input int f, input int exp_row, input int ncyc,
                             input int lc1, input int r1, input int lc2, input int r2);
        logic [7:0]  es;
        logic        eg;
        logic [63:0] segs;
        segs = (exp_row < 0) ? 64'hFFFF_FFFF_FFFF_FFFF : tbl[exp_row].segs;
        for (int c = 0; c < ncyc; c++) begin
            es = ((c % SLOT) >= BC) ? segs[8*(c/SLOT) +: 8] : 8'hFF;
            eg = (es != 8'hFF);
            chk("outputs", f, c,
                {17'd0, sel, g1, g2a, g2b, seg, frame_done, load_ack},
                {17'd0, 3'(c / SLOT), eg, ~eg, ~eg, es, (c == FRAME - 1), prev_load});
            load = 1'b0;
            if (c == lc1 || c == lc2) begin
                load    = 1'b1;
                data_in = tbl[(c == lc1) ? r1 : r2].data;
                mask_in = tbl[(c == lc1) ? r1 : r2].mask;
                dp_in   = tbl[(c == lc1) ? r1 : r2].dp;
            end
            prev_load = load;
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h7654_3210, 8'hFF, 8'h00, 64'h1F41_4999_0D25_9F03};
        tbl[1] = '{32'hFEDC_BA98, 8'h05, 8'h04, 64'hFFFF_FFFF_FF10_FF01};
        tbl[2] = '{32'h89AB_CDEF, 8'hF0, 8'h80, 64'h0009_11C1_FFFF_FFFF};
        tbl[3] = '{32'h0000_0000, 8'h81, 8'h01, 64'h03FF_FFFF_FFFF_FF02};
        tbl[4] = tbl[0];

        // Reset values while held in reset
        repeat (3) step();
        chk("reset", 0, 0, {17'd0, sel, g1, g2a, g2b, seg, frame_done, load_ack},
            {17'd0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0});
        rst_n = 1'b1;

        // Frame 0 dark, load A mid-frame; frame 1 shows A, load B; frame 2 shows B
        run_frame(0, -1, FRAME, 10, 0, -1, 0);
        run_frame(1, 0, FRAME, 20, 1, -1, 0);
        // Tearing: two loads in frame 2, only the second reaches frame 3
        run_frame(2, 1, FRAME, 5, 2, 30, 3);
        // Stale pending A overwritten by a load in the frame_done cycle
        run_frame(3, 3, FRAME, 20, 0, FRAME - 1, 2);
        run_frame(4, 2, FRAME, -1, 0, -1, 0);
        run_frame(5, 2, FRAME, 10, 4, -1, 0);

        // Async reset while slot 3 is lit
        run_frame(6, 4, 3 * SLOT + BC + 1, -1, 0, -1, 0);
        chk("slot3_lit", 6, 21, {21'd0, sel, g1, seg}, {21'd0, 3'd3, 1'b1, 8'h0D});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 6, 21, {21'd0, sel, g1, g2a, g2b, seg},
            {21'd0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hFF});
        prev_load = 1'b0;
        step();
        rst_n = 1'b1;
        run_frame(7, -1, FRAME, -1, 0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
